// File: rtl/botones_debounce.sv
// botones_debounce: conditions five active-low push-buttons into
// registered one-cycle active-low press pulses plus a debounced held level.
// Each channel has a two-flop synchronizer and a four-state debounce FSM.
// Optional feature: define BOTONES_AUTOREPEAT_EN to let the four direction
// channels re-pulse while held (first after REPEAT_DELAY, then every
// REPEAT_CYCLES). The attack channel never repeats.

module botones_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       attack_raw,
    input  logic       izquierda_raw,
    input  logic       arriba_raw,
    input  logic       abajo_raw,
    input  logic       derecha_raw,
    output logic       attack,
    output logic       izquierda,
    output logic       arriba,
    output logic       abajo,
    output logic       derecha,
    output logic [4:0] presionado
);

    localparam int MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_ALL = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
    localparam int CW      = $clog2(MAX_ALL) + 1;

    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_TOP  = '1;
`ifdef BOTONES_AUTOREPEAT_EN
    localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RC_LAST  = CW'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        SUELTO,
        ESPERA_PRESION,
        PRESIONADO,
        ESPERA_SUELTA
    } estado_t;

    // Channel order everywhere: {attack, izquierda, arriba, abajo, derecha}
    logic [4:0] raw_bus;
    logic [4:0] sync_a;
    logic [4:0] sync_b;
    logic [4:0] pulso_bus;
    logic [4:0] held_bus;

    assign raw_bus = {attack_raw, izquierda_raw, arriba_raw, abajo_raw, derecha_raw};

    // Two-flop synchronizer; idles at 1 (released) so reset never looks like a press
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= '1;
            sync_b <= '1;
        end else begin
            sync_a <= raw_bus;
            sync_b <= sync_a;
        end
    end

    for (genvar i = 0; i < 5; i++) begin : g_canal
`ifdef BOTONES_AUTOREPEAT_EN
        localparam bit ES_DIRECCION = (i != 4);
        logic          rep, rep_next;
`endif
        estado_t       estado, estado_next;
        logic [CW-1:0] cnt, cnt_next, cnt_sat;
        logic          pulso_n, pulso_n_next;
        logic          held, held_next;
        logic          s;

        assign s       = sync_b[i];
        assign cnt_sat = (cnt == CNT_TOP) ? cnt : cnt + CW'(1);

        // Next-state logic: debounce both edges, pulse on entry to PRESIONADO
        always_comb begin
            estado_next  = estado;
            cnt_next     = cnt_sat;
            pulso_n_next = 1'b1;
            held_next    = held;
`ifdef BOTONES_AUTOREPEAT_EN
            rep_next     = rep;
`endif
            case (estado)
                SUELTO: begin
                    cnt_next = '0;
                    if (!s) begin
                        estado_next = ESPERA_PRESION;
                    end
                end
                ESPERA_PRESION: begin
                    if (s) begin
                        estado_next = SUELTO;
                        cnt_next    = '0;
                    end else if (cnt == DEB_LAST) begin
                        estado_next  = PRESIONADO;
                        cnt_next     = '0;
                        pulso_n_next = 1'b0;
                        held_next    = 1'b1;
`ifdef BOTONES_AUTOREPEAT_EN
                        rep_next     = 1'b0;
`endif
                    end
                end
                PRESIONADO: begin
                    if (s) begin
                        estado_next = ESPERA_SUELTA;
                        cnt_next    = '0;
                    end
`ifdef BOTONES_AUTOREPEAT_EN
                    else if (ES_DIRECCION &&
                             ((!rep && cnt == RD_LAST) || (rep && cnt == RC_LAST))) begin
                        pulso_n_next = 1'b0;
                        cnt_next     = '0;
                        rep_next     = 1'b1;
                    end
`endif
                end
                ESPERA_SUELTA: begin
                    if (!s) begin
                        estado_next = PRESIONADO;
                        cnt_next    = '0;
`ifdef BOTONES_AUTOREPEAT_EN
                        rep_next    = 1'b0;
`endif
                    end else if (cnt == DEB_LAST) begin
                        estado_next = SUELTO;
                        cnt_next    = '0;
                        held_next   = 1'b0;
                    end
                end
                default: begin
                    estado_next = SUELTO;
                    cnt_next    = '0;
                end
            endcase
        end

        // Channel state register; reset discards any press in progress
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                estado  <= SUELTO;
                cnt     <= '0;
                pulso_n <= 1'b1;
                held    <= 1'b0;
`ifdef BOTONES_AUTOREPEAT_EN
                rep     <= 1'b0;
`endif
            end else begin
                estado  <= estado_next;
                cnt     <= cnt_next;
                pulso_n <= pulso_n_next;
                held    <= held_next;
`ifdef BOTONES_AUTOREPEAT_EN
                rep     <= rep_next;
`endif
            end
        end

        assign pulso_bus[i] = pulso_n;
        assign held_bus[i]  = held;
    end

    assign {attack, izquierda, arriba, abajo, derecha} = pulso_bus;
    assign presionado = held_bus;

endmodule

// File: doc/botones_debounce.md
BOTONES_DEBOUNCE -- requirements
Module: botones_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, meaning stable-level cycles required to accept a press or release (minimum 2).
REQ-002 Parameter REPEAT_DELAY, default 25000000, meaning cycles a direction stays held before the first auto-repeat pulse.
REQ-003 Parameter REPEAT_CYCLES, default 10000000, meaning cycles between subsequent auto-repeat pulses.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 attack_raw, izquierda_raw, arriba_raw, abajo_raw, derecha_raw  input  1 each  raw push-buttons, active-low (0 = pressed), asynchronous to clk.
REQ-007 attack, izquierda, arriba, abajo, derecha  output  1 each  conditioned press events, active-low one-cycle pulses (idle 1), driving the game core's button inputs directly.
REQ-008 presionado  output  5  debounced held level per button, active-high, bit order {attack, izquierda, arriba, abajo, derecha}.

Function
REQ-009 Each raw input passes through a two-flop synchronizer before any other logic; the five channels are independent and identical.
REQ-010 Each channel runs a four-state FSM: SUELTO, ESPERA_PRESION, PRESIONADO, ESPERA_SUELTA, with a counter of width clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_CYCLES))+1.
REQ-011 SUELTO: synchronized 0 -> ESPERA_PRESION, counter cleared.
REQ-012 ESPERA_PRESION: synchronized 1 -> SUELTO, counter cleared. Counter reaching DEBOUNCE_CYCLES-1 while 0 -> PRESIONADO.
REQ-013 Entry into PRESIONADO drives the channel output 0 for exactly one cycle and sets its presionado bit.
REQ-014 PRESIONADO: synchronized 1 -> ESPERA_SUELTA, counter cleared.
REQ-015 ESPERA_SUELTA: synchronized 0 -> PRESIONADO with no new pulse. Counter reaching DEBOUNCE_CYCLES-1 while 1 -> SUELTO and clears the presionado bit.
REQ-016 Latency: a clean raw press first sampled 0 at edge k produces its pulse in the cycle after edge k+DEBOUNCE_CYCLES+2.
REQ-017 Glitches shorter than DEBOUNCE_CYCLES cycles in either direction produce no pulse and no presionado change.
REQ-018 Simultaneous presses on different channels each produce their own pulse in the same cycle; no arbitration.
REQ-019 Counters saturate and never wrap; a button held indefinitely produces exactly one pulse unless auto-repeat applies.
REQ-020 Outputs are registered; no combinational path from raw inputs to outputs.

Reset
REQ-021 reset = 0 asynchronously forces every FSM to SUELTO, clears all counters, sets synchronizer flops to 1, drives attack, izquierda, arriba, abajo, derecha = 1 and presionado = 5'b00000.
REQ-022 Reset asserted mid-debounce or mid-hold discards that press. After release, a still-held button needs a full DEBOUNCE_CYCLES qualification and then pulses once.

Configuration
REQ-023 Macro BOTONES_AUTOREPEAT_EN, when defined: a direction channel (izquierda, arriba, abajo, derecha) held in PRESIONADO re-pulses after REPEAT_DELAY cycles, then every REPEAT_CYCLES cycles, until it leaves PRESIONADO.
REQ-024 The attack channel never auto-repeats.
REQ-025 Without BOTONES_AUTOREPEAT_EN, repeat logic and its parameters are unused and every channel gives exactly one pulse per accepted press.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_CYCLES=4)
REQ-026 Reset with all raw=1, then release reset -> all five outputs 1 and presionado=0 for 50 cycles.
REQ-027 attack_raw=0 held 20 cycles -> attack=0 for exactly one cycle, 6 cycles after first sample; presionado[4]=1 until 4+2 cycles after release.
REQ-028 izquierda_raw pulsed 0 for 3 cycles, then 1 -> no izquierda pulse and presionado stays 0.
REQ-029 arriba_raw and derecha_raw driven 0 on the same edge -> arriba and derecha each pulse 0 in the same cycle.
REQ-030 abajo_raw held 0, reset asserted 2 cycles after the abajo pulse, released while still held -> outputs 1 during reset, then exactly one new abajo pulse 6 cycles later.
REQ-031 With BOTONES_AUTOREPEAT_EN, derecha_raw held 40 cycles -> pulses at press+6, +8, +4, +4, ... while held; attack held 40 cycles -> exactly one pulse.
